motor_cycle_seq: RTL and testbench
==================================

Name: motor_cycle_seq

Overview:
Parametrised successor to the fixed forward/stop/reverse motor direction controller. It runs a closed cycle FWD → STOP_A → REV → STOP_B → FWD with per-phase durations supplied at run time. It adds run enable, pause, an optional cycle limit with a DONE state, and status outputs (remaining time, cycle count, phase-change pulse). It sits downstream of the 1 Hz divider and drives the direction LEDs and the motor-driver direction inputs.

Parameters:
T_W, 6, width of phase-duration inputs and remaining-time counter (seconds)
CNT_W, 8, width of cycle counter and cycle-limit input
LED_W, 6, width of direction pattern output; must be even and ≥2

Ports:
clk1h  in  1  1 Hz tick clock; all state changes occur on its rising edge
rst  in  1  asynchronous, active-low reset
en  in  1  run enable; 1 = run sequence, 0 = return to IDLE
pause  in  1  freeze timer and state while running
t_fwd  in  T_W  forward phase duration, in clk1h periods
t_stop  in  T_W  duration of each stop phase
t_rev  in  T_W  reverse phase duration
max_cycles  in  CNT_W  number of full cycles to run; 0 = run forever
dir  out  LED_W  direction pattern
state  out  3  current state encoding
remain  out  T_W  periods left in the current phase
cycle_cnt  out  CNT_W  completed full cycles since last start
done  out  1  high while in DONE
phase_tick  out  1  one-period pulse after every state change from a phase or IDLE

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, dir=0, remain=0, cycle_cnt=0, done=0, phase_tick=0.
- States: IDLE=0, FWD=1, STOP_A=2, REV=3, STOP_B=4, DONE=5. Codes 6 and 7 recover to IDLE on the next edge.
- dir is registered and decoded from the next state, so it changes on the same edge as state.
  - FWD: lower LED_W/2 bits are 1 (000111 for LED_W=6).
  - REV: upper LED_W/2 bits are 1 (111000).
  - IDLE, STOP_A, STOP_B: all 0.
  - DONE: all 1.
- IDLE → FWD on an edge with en=1. That edge also clears cycle_cnt and loads remain with t_fwd.
- Duration load: each phase loads its duration on entry. A loaded value of 0 is treated as 1. Input changes mid-phase do not affect the current phase.
- In a phase, with pause=0 and en=1:
  - If remain>1: remain decrements.
  - If remain==1: advance to the next phase and load its duration.
  - A phase therefore lasts exactly N clk1h periods.
- Phase order: FWD → STOP_A (t_stop) → REV (t_rev) → STOP_B (t_stop) → FWD.
- Leaving STOP_B:
  - cycle_cnt increments, saturating at all-ones.
  - If max_cycles≠0 and the new count equals max_cycles, go to DONE (remain=0). Otherwise go to FWD.
- DONE: done=1 and dir all-ones. State holds until en=0, then goes to IDLE on the next edge. cycle_cnt holds until the next start.
- pause=1 in a phase: state, remain and dir frozen. Ignored in IDLE and DONE.
- en=0 in any non-IDLE state: IDLE on the next edge, dir=0, remain=0, cycle_cnt retained.
- Priority on one edge: en=0 > pause > expiry.
- phase_tick: registered. It is 1 for the period following any edge where state changed, except entries caused by en=0.
- Widths: remain is T_W bits unsigned. No arithmetic wraps (decrement only from ≥2; cycle_cnt saturates).

Decomposition:
- Package motor_seq_pkg holds:
  - state encodings
  - a function returning the dir pattern for a given state and LED_W
  - the constant for the default pattern
- One natural sub-module, phase_timer. It is a T_W-bit loadable down-counter with load, hold and an expire flag (remain==1). Clamp-to-1 on load is done inside it.
- The FSM, cycle counter and output registers stay in motor_cycle_seq.

Test Plan:
- Reset: hold rst=0 across edges with en=1 → state=0, dir=000000, remain=0, done=0. Release rst; first edge with en=1 → state=FWD, dir=000111, remain=t_fwd, phase_tick=1 next period.
- Basic cycle, t_fwd=3, t_stop=2, t_rev=3, max_cycles=0, en from edge 1:
  - FWD for edges 1–3, STOP_A 4–5, REV 6–8, STOP_B 9–10, FWD again at edge 11.
  - cycle_cnt=1 after edge 11.
  - dir sequence: 000111, 000000, 111000, 000000.
- Cycle limit, same durations, max_cycles=2 → DONE at edge 21: done=1, dir=111111, cycle_cnt=2. Drop en → IDLE next edge, dir=0.
- Pause: assert pause for 4 edges during REV with remain=2 → remain stays 2 and dir stays 111000. Release → REV lasts 2 more periods, then STOP_B.
- Zero duration and mid-run abort:
  - t_stop=0 → each stop phase lasts exactly 1 period.
  - en=0 on the same edge as remain==1 in FWD → IDLE (not STOP_A), phase_tick=0.
- Async reset mid-REV: pulse rst low between clk1h edges → outputs return to reset values immediately, without waiting for an edge.

Source files
------------

// File: rtl/motor_seq_pkg.sv
// Shared encodings and direction-pattern helper
// for the motor cycle sequencer.
package motor_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FWD    = 3'd1,
        ST_STOP_A = 3'd2,
        ST_REV    = 3'd3,
        ST_STOP_B = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    localparam logic [63:0] DIR_DEFAULT = 64'd0;

    // Direction pattern for a state; caller truncates to its LED width.
    function automatic logic [63:0] dir_pattern(state_t s, int w);
        logic [63:0] lo;
        logic [63:0] all;
        lo  = (64'd1 << (w / 2)) - 64'd1;
        all = (64'd1 << w) - 64'd1;
        unique case (s)
            ST_FWD:  return lo;
            ST_REV:  return all ^ lo;
            ST_DONE: return all;
            default: return DIR_DEFAULT;
        endcase
    endfunction

endpackage

// File: rtl/motor_cycle_seq_phase_timer.sv
// Loadable down-counter holding the time left in a phase.
// A zero load is promoted to one so every phase lasts at least a period.
module phase_timer #(
    parameter int T_W = 6
) (
    input  logic           clk1h,
    input  logic           rst,
    input  logic           clr,
    input  logic           load,
    input  logic           dec,
    input  logic [T_W-1:0] load_val,
    output logic [T_W-1:0] remain,
    output logic           expire
);

    // Clear, load (clamped), or count down; never below one.
    always_ff @(posedge clk1h or negedge rst) begin
        if (!rst) begin
            remain <= '0;
        end else if (clr) begin
            remain <= '0;
        end else if (load) begin
            remain <= (load_val == '0) ? T_W'(1) : load_val;
        end else if (dec && remain > T_W'(1)) begin
            remain <= remain - T_W'(1);
        end
    end

    assign expire = (remain == T_W'(1));

endmodule

// File: rtl/motor_cycle_seq.sv
// Forward/stop/reverse/stop motor cycle with run-time phase lengths,
// pause, optional cycle limit and status outputs.
module motor_cycle_seq
    import motor_seq_pkg::*;
#(
    parameter int T_W   = 6,
    parameter int CNT_W = 8,
    parameter int LED_W = 6
) (
    input  logic             clk1h,
    input  logic             rst,
    input  logic             en,
    input  logic             pause,
    input  logic [T_W-1:0]   t_fwd,
    input  logic [T_W-1:0]   t_stop,
    input  logic [T_W-1:0]   t_rev,
    input  logic [CNT_W-1:0] max_cycles,
    output logic [LED_W-1:0] dir,
    output logic [2:0]       state,
    output logic [T_W-1:0]   remain,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             done,
    output logic             phase_tick
);

    state_t           cur;
    state_t           nxt;
    logic             t_clr;
    logic             t_load;
    logic             t_dec;
    logic [T_W-1:0]   t_val;
    logic             expire;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             tick_n;
    logic [CNT_W-1:0] cnt_sat;

    phase_timer #(.T_W(T_W)) u_timer (
        .clk1h    (clk1h),
        .rst      (rst),
        .clr      (t_clr),
        .load     (t_load),
        .dec      (t_dec),
        .load_val (t_val),
        .remain   (remain),
        .expire   (expire)
    );

    assign cnt_sat = (cycle_cnt == '1) ? cycle_cnt
                                       : cycle_cnt + CNT_W'(1);

    // Next state, timer control and counter control.
    always_comb begin
        nxt     = cur;
        t_clr   = 1'b0;
        t_load  = 1'b0;
        t_dec   = 1'b0;
        t_val   = t_fwd;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        tick_n  = 1'b0;
        unique case (cur)
            ST_IDLE: begin
                if (en) begin
                    nxt     = ST_FWD;
                    t_load  = 1'b1;
                    cnt_clr = 1'b1;
                    tick_n  = 1'b1;
                end
            end
            ST_FWD, ST_STOP_A, ST_REV, ST_STOP_B: begin
                if (!en) begin
                    nxt   = ST_IDLE;
                    t_clr = 1'b1;
                end else if (pause) begin
                    nxt = cur;
                end else if (expire) begin
                    tick_n = 1'b1;
                    t_load = 1'b1;
                    unique case (cur)
                        ST_FWD: begin
                            nxt   = ST_STOP_A;
                            t_val = t_stop;
                        end
                        ST_STOP_A: begin
                            nxt   = ST_REV;
                            t_val = t_rev;
                        end
                        ST_REV: begin
                            nxt   = ST_STOP_B;
                            t_val = t_stop;
                        end
                        default: begin
                            cnt_inc = 1'b1;
                            if (max_cycles != '0 &&
                                cnt_sat == max_cycles) begin
                                nxt    = ST_DONE;
                                t_load = 1'b0;
                                t_clr  = 1'b1;
                            end else begin
                                nxt = ST_FWD;
                            end
                        end
                    endcase
                end else begin
                    t_dec = 1'b1;
                end
            end
            ST_DONE: begin
                if (!en) nxt = ST_IDLE;
            end
            default: begin
                nxt   = ST_IDLE;
                t_clr = 1'b1;
            end
        endcase
    end

    // State, direction, status and cycle counter registers.
    always_ff @(posedge clk1h or negedge rst) begin
        if (!rst) begin
            cur        <= ST_IDLE;
            dir        <= '0;
            done       <= 1'b0;
            phase_tick <= 1'b0;
            cycle_cnt  <= '0;
        end else begin
            cur        <= nxt;
            dir        <= LED_W'(dir_pattern(nxt, LED_W));
            done       <= (nxt == ST_DONE);
            phase_tick <= tick_n;
            if (cnt_clr)      cycle_cnt <= '0;
            else if (cnt_inc) cycle_cnt <= cnt_sat;
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_motor_cycle_seq.sv
// Directed bench for motor_cycle_seq with hand-computed expectations.
module tb_motor_cycle_seq;

    logic       clk1h;
    logic       rst;
    logic       en;
    logic       pause;
    logic [5:0] t_fwd;
    logic [5:0] t_stop;
    logic [5:0] t_rev;
    logic [7:0] max_cycles;
    logic [5:0] dir;
    logic [2:0] state;
    logic [5:0] remain;
    logic [7:0] cycle_cnt;
    logic       done;
    logic       phase_tick;

    int vectors = 0;
    int errs    = 0;

    int exp_st[11]  = '{1, 1, 1, 2, 2, 3, 3, 3, 4, 4, 1};
    int exp_rm[11]  = '{3, 2, 1, 2, 1, 3, 2, 1, 2, 1, 3};
    int exp_tk[11]  = '{1, 0, 0, 1, 0, 1, 0, 0, 1, 0, 1};
    int exp_dir[11] = '{7, 7, 7, 0, 0, 56, 56, 56, 0, 0, 7};

    motor_cycle_seq #(.T_W(6), .CNT_W(8), .LED_W(6)) dut (
        .clk1h      (clk1h),
        .rst        (rst),
        .en         (en),
        .pause      (pause),
        .t_fwd      (t_fwd),
        .t_stop     (t_stop),
        .t_rev      (t_rev),
        .max_cycles (max_cycles),
        .dir        (dir),
        .state      (state),
        .remain     (remain),
        .cycle_cnt  (cycle_cnt),
        .done       (done),
        .phase_tick (phase_tick)
    );

    initial clk1h = 1'b0;
    always #5 clk1h = ~clk1h;

    task automatic step();
        @(posedge clk1h);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    initial begin
        rst        = 1'b0;
        en         = 1'b1;
        pause      = 1'b0;
        t_fwd      = 6'd3;
        t_stop     = 6'd2;
        t_rev      = 6'd3;
        max_cycles = 8'd0;

        // reset held across edges with en=1
        step();
        step();
        chk("rst_state", state, 0);
        chk("rst_dir", dir, 0);
        chk("rst_remain", remain, 0);
        chk("rst_done", done, 0);
        chk("rst_tick", phase_tick, 0);
        chk("rst_cnt", cycle_cnt, 0);
        rst = 1'b1;

        // basic free-running cycle, edges 1..11
        for (int k = 0; k < 11; k++) begin
            step();
            chk($sformatf("basic_st_e%0d", k + 1), state, exp_st[k]);
            chk($sformatf("basic_rm_e%0d", k + 1), remain, exp_rm[k]);
            chk($sformatf("basic_tk_e%0d", k + 1), phase_tick, exp_tk[k]);
            chk($sformatf("basic_dir_e%0d", k + 1), dir, exp_dir[k]);
        end
        chk("basic_cnt", cycle_cnt, 1);

        // abort, cycle count retained
        en = 1'b0;
        step();
        chk("abort_state", state, 0);
        chk("abort_dir", dir, 0);
        chk("abort_tick", phase_tick, 0);
        chk("abort_cnt", cycle_cnt, 1);

        // cycle limit of two
        max_cycles = 8'd2;
        en = 1'b1;
        step();
        chk("lim_start_cnt", cycle_cnt, 0);
        for (int k = 2; k <= 20; k++) step();
        chk("lim_e20_state", state, 4);
        chk("lim_e20_remain", remain, 1);
        step();
        chk("lim_done_state", state, 5);
        chk("lim_done", done, 1);
        chk("lim_done_dir", dir, 63);
        chk("lim_done_cnt", cycle_cnt, 2);
        chk("lim_done_remain", remain, 0);
        chk("lim_done_tick", phase_tick, 1);
        step();
        chk("lim_hold_state", state, 5);
        chk("lim_hold_tick", phase_tick, 0);
        en = 1'b0;
        step();
        chk("lim_exit_state", state, 0);
        chk("lim_exit_dir", dir, 0);
        chk("lim_exit_done", done, 0);
        chk("lim_exit_cnt", cycle_cnt, 2);

        // pause during REV with remain=2
        max_cycles = 8'd0;
        en = 1'b1;
        for (int k = 1; k <= 7; k++) step();
        chk("pz_pre_state", state, 3);
        chk("pz_pre_remain", remain, 2);
        pause = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("pz_st_%0d", k), state, 3);
            chk($sformatf("pz_rm_%0d", k), remain, 2);
            chk($sformatf("pz_dir_%0d", k), dir, 56);
        end
        pause = 1'b0;
        step();
        chk("pz_rel_state", state, 3);
        chk("pz_rel_remain", remain, 1);
        step();
        chk("pz_next_state", state, 4);
        chk("pz_next_remain", remain, 2);

        // zero stop duration takes effect from the next stop phase
        t_stop = 6'd0;
        step();
        chk("z_stopb_remain", remain, 1);
        step();
        chk("z_fwd_state", state, 1);
        chk("z_fwd_cnt", cycle_cnt, 1);
        step();
        step();
        step();
        chk("z_stopa_state", state, 2);
        chk("z_stopa_remain", remain, 1);
        step();
        chk("z_rev_state", state, 3);
        chk("z_rev_remain", remain, 3);
        step();
        step();
        step();
        chk("z_stopb_state", state, 4);
        chk("z_stopb1_remain", remain, 1);
        step();
        chk("z_wrap_state", state, 1);
        chk("z_wrap_cnt", cycle_cnt, 2);
        step();
        step();
        chk("z_expire_remain", remain, 1);

        // en drop on the expiry edge beats the phase advance
        en = 1'b0;
        step();
        chk("ab_state", state, 0);
        chk("ab_tick", phase_tick, 0);
        chk("ab_remain", remain, 0);
        chk("ab_cnt", cycle_cnt, 2);

        // async reset in the middle of REV
        en = 1'b1;
        for (int k = 1; k <= 6; k++) step();
        chk("ar_pre_state", state, 3);
        chk("ar_pre_remain", remain, 2);
        #3;
        rst = 1'b0;
        #1;
        chk("ar_state", state, 0);
        chk("ar_dir", dir, 0);
        chk("ar_remain", remain, 0);
        chk("ar_cnt", cycle_cnt, 0);
        chk("ar_done", done, 0);
        rst = 1'b1;
        step();
        chk("ar_restart_state", state, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
